// File: rtl/ldpc_3gpp_enc_sink_var.sv
// Runtime-configurable LDPC encoder output sink with circular-buffer rate matching.
// Define LDPC_3GPP_ENC_SINK_VAR_OREG_EN to add one output register stage (latency 4).
module ldpc_3gpp_enc_sink_var #(
  parameter int unsigned pADDR_W = 12,
  parameter int unsigned pDAT_W  = 8,
  parameter int unsigned pTAG_W  = 4,
  parameter int unsigned pZC_W   = 9,
  parameter int unsigned pLEN_W  = 16
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic               iclkena,
  input  logic               igr,
  input  logic [pZC_W-1:0]   izc,
  input  logic [5:0]         icode,
  input  logic               ipunct,
  input  logic [pLEN_W-1:0]  ilen,
  input  logic               ifull,
  input  logic [pDAT_W-1:0]  irdat,
  input  logic [pTAG_W-1:0]  irtag,
  output logic               orempty,
  output logic [pADDR_W-1:0] oraddr,
  input  logic               ireq,
  output logic               ofull,
  output logic               osop,
  output logic               oval,
  output logic               oeop,
  output logic [pDAT_W-1:0]  odat,
  output logic [pTAG_W-1:0]  otag
);

  localparam int unsigned N_W    = pADDR_W + 1;
  localparam int unsigned NCOL_W = 7;
  localparam int unsigned PROD_W = NCOL_W + pZC_W;

  typedef enum logic [1:0] {IDLE, SETUP, RUN, DRAIN} state_t;

  state_t state_q, state_d;

  logic               gr_q, gr_d;
  logic [pZC_W-1:0]   zc_q, zc_d;
  logic [5:0]         code_q, code_d;
  logic               punct_q, punct_d;
  logic [pLEN_W-1:0]  len_q, len_d;
  logic [N_W-1:0]     n_q, n_d;
  logic [pADDR_W-1:0] s_q, s_d;
  logic [pLEN_W-1:0]  rem_q, rem_d;
  logic               first_q, first_d;
  logic [pADDR_W-1:0] oraddr_q, oraddr_d;
  logic               ofull_q, ofull_d;
  logic               orempty_q, orempty_d;

  logic               p1_val_q, p1_val_d, p1_sop_q, p1_sop_d, p1_eop_q, p1_eop_d;
  logic               p2_val_q, p2_val_d, p2_sop_q, p2_sop_d, p2_eop_q, p2_eop_d;
  logic               val3_q, val3_d, sop3_q, sop3_d, eop3_q, eop3_d;
  logic [pDAT_W-1:0]  dat3_q, dat3_d;
  logic [pTAG_W-1:0]  tag3_q, tag3_d;

  logic [5:0]         code_eff_c;
  logic [NCOL_W-1:0]  ncol_c;
  logic [PROD_W-1:0]  prod_c;
  logic [N_W-1:0]     n_c;
  logic [pADDR_W-1:0] s_c;
  logic [pLEN_W-1:0]  nat_len_c;
  logic               issue_c;
  logic               wrap_c;
  logic               last_c;

  // Frame geometry from the captured per-frame parameters
  always_comb begin
    code_eff_c = (code_q < 6'd4) ? 6'd4 : code_q;
    ncol_c     = (gr_q ? NCOL_W'(10) : NCOL_W'(22)) + NCOL_W'(code_eff_c);
    prod_c     = PROD_W'(ncol_c) * PROD_W'(zc_q);
    n_c        = N_W'(prod_c);
    s_c        = punct_q ? pADDR_W'({zc_q, 1'b0}) : '0;
    nat_len_c  = pLEN_W'(n_c - N_W'(s_c));
    issue_c    = (state_q == RUN) && ireq && (rem_q != '0);
    wrap_c     = (oraddr_q == pADDR_W'(n_q - N_W'(1)));
    last_c     = (rem_q == pLEN_W'(1));
  end

  // Next-state, address generation and read pipeline
  always_comb begin
    state_d   = state_q;
    gr_d      = gr_q;
    zc_d      = zc_q;
    code_d    = code_q;
    punct_d   = punct_q;
    len_d     = len_q;
    n_d       = n_q;
    s_d       = s_q;
    rem_d     = rem_q;
    first_d   = first_q;
    oraddr_d  = oraddr_q;
    ofull_d   = ofull_q;

    case (state_q)
      IDLE: begin
        if (ifull) begin
          gr_d    = igr;
          zc_d    = izc;
          code_d  = icode;
          punct_d = ipunct;
          len_d   = ilen;
          state_d = SETUP;
        end
      end
      SETUP: begin
        n_d      = n_c;
        s_d      = s_c;
        oraddr_d = s_c;
        rem_d    = (len_q == '0) ? nat_len_c : len_q;
        first_d  = 1'b1;
        ofull_d  = 1'b1;
        state_d  = RUN;
      end
      RUN: begin
        if (rem_q == '0) begin
          ofull_d = 1'b0;
          state_d = IDLE;
        end else if (issue_c) begin
          rem_d    = rem_q - pLEN_W'(1);
          oraddr_d = wrap_c ? s_q : oraddr_q + pADDR_W'(1);
          first_d  = 1'b0;
          if (last_c) begin
            ofull_d = 1'b0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Release completes once the bank-release pulse has been presented
        if (orempty_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    p1_val_d = issue_c;
    p1_sop_d = issue_c & first_q;
    p1_eop_d = issue_c & last_c;
    p2_val_d = p1_val_q;
    p2_sop_d = p1_sop_q;
    p2_eop_d = p1_eop_q;
    val3_d   = p2_val_q;
    sop3_d   = p2_val_q & p2_sop_q;
    eop3_d   = p2_val_q & p2_eop_q;
    dat3_d   = p2_val_q ? irdat : dat3_q;
    tag3_d   = (p2_val_q & p2_sop_q) ? irtag : tag3_q;
`ifdef LDPC_3GPP_ENC_SINK_VAR_OREG_EN
    orempty_d = val3_q & eop3_q;
`else
    orempty_d = p2_val_q & p2_eop_q;
`endif
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      state_q   <= IDLE;
      gr_q      <= 1'b0;
      zc_q      <= '0;
      code_q    <= '0;
      punct_q   <= 1'b0;
      len_q     <= '0;
      n_q       <= '0;
      s_q       <= '0;
      rem_q     <= '0;
      first_q   <= 1'b0;
      oraddr_q  <= '0;
      ofull_q   <= 1'b0;
      orempty_q <= 1'b0;
      p1_val_q  <= 1'b0;
      p1_sop_q  <= 1'b0;
      p1_eop_q  <= 1'b0;
      p2_val_q  <= 1'b0;
      p2_sop_q  <= 1'b0;
      p2_eop_q  <= 1'b0;
      val3_q    <= 1'b0;
      sop3_q    <= 1'b0;
      eop3_q    <= 1'b0;
      dat3_q    <= '0;
      tag3_q    <= '0;
    end else if (iclkena) begin
      state_q   <= state_d;
      gr_q      <= gr_d;
      zc_q      <= zc_d;
      code_q    <= code_d;
      punct_q   <= punct_d;
      len_q     <= len_d;
      n_q       <= n_d;
      s_q       <= s_d;
      rem_q     <= rem_d;
      first_q   <= first_d;
      oraddr_q  <= oraddr_d;
      ofull_q   <= ofull_d;
      orempty_q <= orempty_d;
      p1_val_q  <= p1_val_d;
      p1_sop_q  <= p1_sop_d;
      p1_eop_q  <= p1_eop_d;
      p2_val_q  <= p2_val_d;
      p2_sop_q  <= p2_sop_d;
      p2_eop_q  <= p2_eop_d;
      val3_q    <= val3_d;
      sop3_q    <= sop3_d;
      eop3_q    <= eop3_d;
      dat3_q    <= dat3_d;
      tag3_q    <= tag3_d;
    end
  end

  assign oraddr  = oraddr_q;
  assign ofull   = ofull_q;
  assign orempty = orempty_q;

`ifdef LDPC_3GPP_ENC_SINK_VAR_OREG_EN
  logic              oval_q, oval_d, osop_q, osop_d, oeop_q, oeop_d;
  logic [pDAT_W-1:0] odat_q, odat_d;
  logic [pTAG_W-1:0] otag_q, otag_d;

  // Extra output retiming stage
  always_comb begin
    oval_d = val3_q;
    osop_d = sop3_q;
    oeop_d = eop3_q;
    odat_d = dat3_q;
    otag_d = tag3_q;
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      oval_q <= 1'b0;
      osop_q <= 1'b0;
      oeop_q <= 1'b0;
      odat_q <= '0;
      otag_q <= '0;
    end else if (iclkena) begin
      oval_q <= oval_d;
      osop_q <= osop_d;
      oeop_q <= oeop_d;
      odat_q <= odat_d;
      otag_q <= otag_d;
    end
  end

  assign oval = oval_q;
  assign osop = osop_q;
  assign oeop = oeop_q;
  assign odat = odat_q;
  assign otag = otag_q;
`else
  assign oval = val3_q;
  assign osop = sop3_q;
  assign oeop = eop3_q;
  assign odat = dat3_q;
  assign otag = tag3_q;
`endif

endmodule
